// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-address generator: data width, default
// reset/trap addresses and the sequencing state encoding.
package pc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bus of pc_gen: redirect/hold requests in, fetch address out.
// The slave modport is the pc_gen view; master is the pipeline/memory view.
interface pc_gen_if;
    import pc_pkg::*;

    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            stall;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_err;

    modport master (
        output branch_taken, branch_target, stall, fetch_ready,
        input  fetch_valid, pc, pc_plus4, misalign_err
    );

    modport slave (
        input  branch_taken, branch_target, stall, fetch_ready,
        output fetch_valid, pc, pc_plus4, misalign_err
    );

endinterface

// File: rtl/pc_redirect_hold.sv
// Pending redirect target plus its valid bit. Only the valid bit is reset;
// the target is don't-care whenever valid is low.
module pc_redirect_hold
    import pc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] target_in,
    output logic [XLEN-1:0] target_out,
    output logic            valid
);

    logic [XLEN-1:0] target_p0;
    logic            vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (capture) begin
            vld_p0 <= 1'b1;
        end else if (clear) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            target_p0 <= target_in;
        end
    end

    assign target_out = target_p0;
    assign valid      = vld_p0;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: BOOT/FETCH/HOLD sequencing with a held redirect.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned taken targets load TRAP_PC and pulse misalign_err.
module pc_gen
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_p0, pc_d;
    logic [XLEN-1:0] hold_target, raw_target;
    logic            vld_p0, advance, redirect;
    logic            hold_valid, hold_capture, hold_clear;

`ifdef PC_MISALIGN_TRAP_EN
    function automatic logic [XLEN-1:0] resolve_target(input logic [XLEN-1:0] t);
        return (t[1:0] != 2'b00) ? TRAP_PC : t;
    endfunction
`else
    function automatic logic [XLEN-1:0] resolve_target(input logic [XLEN-1:0] t);
        return t & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction
`endif

    assign vld_p0  = (state_q != BOOT);
    assign advance = vld_p0 && bus.fetch_ready && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // BOOT is a single cycle; branch_taken is only observed once fetching.
    always_comb begin
        state_d      = state_q;
        hold_capture = 1'b0;
        hold_clear   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (!advance && bus.branch_taken) begin
                    hold_capture = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    hold_clear = 1'b1;
                    state_d    = FETCH;
                end else if (bus.branch_taken) begin
                    hold_capture = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    pc_redirect_hold u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (hold_capture),
        .clear      (hold_clear),
        .target_in  (bus.branch_target),
        .target_out (hold_target),
        .valid      (hold_valid)
    );

    // A held redirect outranks a live one, which outranks sequential fetch.
    always_comb begin
        redirect   = hold_valid || bus.branch_taken;
        raw_target = hold_valid ? hold_target : bus.branch_target;
        pc_d       = redirect ? resolve_target(raw_target) : pc_p0 + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= RESET_PC;
        end else if (advance) begin
            pc_p0 <= pc_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_p0 <= 1'b0;
        end else begin
            misalign_p0 <= advance && redirect && (raw_target[1:0] != 2'b00);
        end
    end

    assign bus.misalign_err = misalign_p0;
`else
    logic unused_trap_pc;

    assign unused_trap_pc   = ^TRAP_PC;
    assign bus.misalign_err = 1'b0;
`endif

    assign bus.fetch_valid = vld_p0;
    assign bus.pc          = pc_p0;
    assign bus.pc_plus4    = pc_p0 + 32'd4;

endmodule
